// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; combinational lookup, synchronous training.
// Define BTB_STATS_EN to build the update/mispredict statistics counters.
module btb_predictor #(
    parameter int DBITS    = 32,
    parameter int IDXBITS  = 4,
    parameter int INSTSIZE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] pc_fe,
    output logic [DBITS-1:0] pcpred_fe,
    output logic             predtaken_fe,
    input  logic             upd_valid,
    input  logic [DBITS-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [DBITS-1:0] upd_target,
    input  logic             upd_mispred,
    output logic [31:0]      stat_updates,
    output logic [31:0]      stat_mispreds
);
    localparam int          TAGBITS = DBITS - 2 - IDXBITS;
    localparam int unsigned NENT    = 1 << IDXBITS;

    logic               r_valid  [NENT];
    logic [TAGBITS-1:0] r_tag    [NENT];
    logic [DBITS-1:0]   r_target [NENT];
    logic [1:0]         r_ctr    [NENT];

    logic [IDXBITS-1:0] w_idx;
    logic [TAGBITS-1:0] w_tag;
    logic               w_hit;
    logic [IDXBITS-1:0] w_uidx;
    logic [TAGBITS-1:0] w_utag;
    logic               w_uhit;
    logic               w_unused;

    assign w_idx  = pc_fe[IDXBITS+1:2];
    assign w_tag  = pc_fe[DBITS-1:IDXBITS+2];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_uidx = upd_pc[IDXBITS+1:2];
    assign w_utag = upd_pc[DBITS-1:IDXBITS+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    // Lookup reads the registered table, so a same-cycle update is not forwarded.
    always_comb begin
        predtaken_fe = w_hit && r_ctr[w_idx][1];
        pcpred_fe    = predtaken_fe ? r_target[w_idx] : pc_fe + DBITS'(INSTSIZE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NENT; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_uhit) begin
                if (upd_taken) begin
                    r_ctr[w_uidx]    <= (r_ctr[w_uidx] == 2'b11) ? 2'b11 : r_ctr[w_uidx] + 2'd1;
                    r_target[w_uidx] <= upd_target;
                end else begin
                    r_ctr[w_uidx] <= (r_ctr[w_uidx] == 2'b00) ? 2'b00 : r_ctr[w_uidx] - 2'd1;
                end
            end else if (upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd_target;
                r_ctr[w_uidx]    <= 2'b10;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_mispreds;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_updates  <= '0;
            r_stat_mispreds <= '0;
        end else if (upd_valid) begin
            r_stat_updates <= r_stat_updates + 32'd1;
            if (upd_mispred)
                r_stat_mispreds <= r_stat_mispreds + 32'd1;
        end
    end

    assign stat_updates  = r_stat_updates;
    assign stat_mispreds = r_stat_mispreds;
    assign w_unused      = ^upd_pc[1:0];
`else
    assign stat_updates  = '0;
    assign stat_mispreds = '0;
    assign w_unused      = ^{upd_pc[1:0], upd_mispred};
`endif

endmodule
